ifm_addr_gen: RTL and testbench



---
 rtl/ifm_addr_gen_pkg.sv | 33 +++
 rtl/ifm_addr_gen_if.sv | 26 ++
 rtl/ifm_addr_cnt.sv | 38 +++
 rtl/ifm_addr_gen.sv | 134 +++++++++++++
 tb/tb_ifm_addr_gen.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ifm_addr_gen_pkg.sv
// Shared types and derived-geometry helpers for the IFM address generator.
package ifm_addr_gen_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_EMIT = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  function automatic int unsigned win_len(input int unsigned k, input int unsigned c);
    return k * k * c;
  endfunction

  function automatic int unsigned cols(input int unsigned ifm, input int unsigned k,
                                       input int unsigned step);
    return (ifm - k) / step + 1;
  endfunction

  function automatic int unsigned rows(input int unsigned ifm, input int unsigned k,
                                       input int unsigned stride);
    return (ifm - k) / stride + 1;
  endfunction

  function automatic int unsigned plane(input int unsigned ifm);
    return ifm * ifm;
  endfunction

  // A modulus of 1 still needs a 1-bit counter register.
  function automatic int unsigned cnt_width(input int unsigned modulus);
    return (modulus > 1) ? $clog2(modulus) : 1;
  endfunction

endpackage

// File: rtl/ifm_addr_gen_if.sv
// Handshake bundle between layer sequencer / IFM buffer and ifm_addr_gen.
// win_last is present only when IFM_ADDR_GEN_LAST_EN is defined.
interface ifm_addr_gen_if #(
  parameter int unsigned ADDR_WIDTH = 19
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] ifm_base;
  logic                  addr_ready;
  logic [ADDR_WIDTH-1:0] ifm_addr;
  logic                  addr_valid;
  logic                  busy;
  logic                  done;
`ifdef IFM_ADDR_GEN_LAST_EN
  logic                  win_last;

  modport master (output start, ifm_base, addr_ready,
                  input  ifm_addr, addr_valid, busy, done, win_last);
  modport slave  (input  start, ifm_base, addr_ready,
                  output ifm_addr, addr_valid, busy, done, win_last);
`else
  modport master (output start, ifm_base, addr_ready,
                  input  ifm_addr, addr_valid, busy, done);
  modport slave  (input  start, ifm_base, addr_ready,
                  output ifm_addr, addr_valid, busy, done);
`endif
endinterface

// File: rtl/ifm_addr_cnt.sv
// Wrap-around loop counter: counts 0..MODULUS-1 on en, cleared by clr.
module ifm_addr_cnt
  import ifm_addr_gen_pkg::*;
#(
  parameter int unsigned MODULUS = 3,
  parameter int unsigned WIDTH   = cnt_width(MODULUS)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic at_max,
  output logic wrap
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  assign at_max = (cnt_q == WIDTH'(MODULUS - 1));
  assign wrap   = en & at_max;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = at_max ? '0 : cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ifm_addr_gen.sv
// Walks a KxKxC window over the IFM plane, one address per ready/valid handshake.
// Optional win_last output enabled by IFM_ADDR_GEN_LAST_EN.
module ifm_addr_gen
  import ifm_addr_gen_pkg::*;
#(
  parameter int unsigned KERNEL_SIZE = 3,
  parameter int unsigned STRIDE      = 1,
  parameter int unsigned COL_STEP    = 16,
  parameter int unsigned IFM_SIZE    = 34,
  parameter int unsigned IFM_CHANNEL = 3,
  parameter int unsigned ADDR_WIDTH  = 19
) (
  input  logic          clk,
  input  logic          rst,
  ifm_addr_gen_if.slave bus
);

  localparam int unsigned COLS_N = cols(IFM_SIZE, KERNEL_SIZE, COL_STEP);
  localparam int unsigned ROWS_N = rows(IFM_SIZE, KERNEL_SIZE, STRIDE);

  localparam logic [ADDR_WIDTH-1:0] KY_INC  = ADDR_WIDTH'(IFM_SIZE);
  localparam logic [ADDR_WIDTH-1:0] CH_INC  = ADDR_WIDTH'(plane(IFM_SIZE));
  localparam logic [ADDR_WIDTH-1:0] COL_INC = ADDR_WIDTH'(COL_STEP);
  localparam logic [ADDR_WIDTH-1:0] ROW_INC = ADDR_WIDTH'(STRIDE * IFM_SIZE);

  state_t state_q, state_d;

  // Nested origins: row of windows > window > channel > kernel line > address.
  logic [ADDR_WIDTH-1:0] row_q, row_d, win_q, win_d, chan_q, chan_d;
  logic [ADDR_WIDTH-1:0] line_q, line_d, addr_q, addr_d;

  logic hs, clr, win_end;
  logic kx_max, ky_max, ch_max, col_max, row_max;
  logic kx_wrap, ky_wrap, ch_wrap, col_wrap, row_wrap;

  assign hs      = (state_q == ST_EMIT) & bus.addr_ready;
  assign clr     = (state_q == ST_IDLE) & bus.start;
  assign win_end = kx_max & ky_max & ch_max;

  ifm_addr_cnt #(.MODULUS(KERNEL_SIZE)) u_kx (
    .clk(clk), .rst(rst), .clr(clr), .en(hs), .at_max(kx_max), .wrap(kx_wrap)
  );
  ifm_addr_cnt #(.MODULUS(KERNEL_SIZE)) u_ky (
    .clk(clk), .rst(rst), .clr(clr), .en(hs & kx_max), .at_max(ky_max), .wrap(ky_wrap)
  );
  ifm_addr_cnt #(.MODULUS(IFM_CHANNEL)) u_ch (
    .clk(clk), .rst(rst), .clr(clr), .en(hs & kx_max & ky_max), .at_max(ch_max),
    .wrap(ch_wrap)
  );
  ifm_addr_cnt #(.MODULUS(COLS_N)) u_col (
    .clk(clk), .rst(rst), .clr(clr), .en(hs & win_end), .at_max(col_max), .wrap(col_wrap)
  );
  ifm_addr_cnt #(.MODULUS(ROWS_N)) u_row (
    .clk(clk), .rst(rst), .clr(clr), .en(hs & win_end & col_max), .at_max(row_max),
    .wrap(row_wrap)
  );

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    win_d   = win_q;
    chan_d  = chan_q;
    line_d  = line_q;
    addr_d  = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_EMIT;
          row_d   = bus.ifm_base;
          win_d   = bus.ifm_base;
          chan_d  = bus.ifm_base;
          line_d  = bus.ifm_base;
          addr_d  = bus.ifm_base;
        end
      end
      ST_EMIT: begin
        if (hs) begin
          if (row_wrap) begin
            state_d = ST_DONE;
          end else if (col_wrap & ~row_max) begin
            row_d  = row_q + ROW_INC;
            win_d  = row_d;
            chan_d = row_d;
            line_d = row_d;
            addr_d = row_d;
          end else if (ch_wrap) begin
            win_d  = win_q + COL_INC;
            chan_d = win_d;
            line_d = win_d;
            addr_d = win_d;
          end else if (ky_wrap) begin
            chan_d = chan_q + CH_INC;
            line_d = chan_d;
            addr_d = chan_d;
          end else if (kx_wrap) begin
            line_d = line_q + KY_INC;
            addr_d = line_d;
          end else begin
            addr_d = addr_q + ADDR_WIDTH'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      win_q   <= '0;
      chan_q  <= '0;
      line_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      win_q   <= win_d;
      chan_q  <= chan_d;
      line_q  <= line_d;
      addr_q  <= addr_d;
    end
  end

  assign bus.ifm_addr   = addr_q;
  assign bus.addr_valid = (state_q == ST_EMIT);
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.done       = (state_q == ST_DONE);
`ifdef IFM_ADDR_GEN_LAST_EN
  assign bus.win_last   = (state_q == ST_EMIT) & win_end;
`endif

endmodule

// File: tb/tb_ifm_addr_gen.sv
// Bench for ifm_addr_gen: default-parameter DUT plus an alternate-geometry DUT,
// both compared every cycle against an index-based address model.
module tb_ifm_addr_gen;

  localparam int unsigned AW   = 19;
  localparam int          TOT1 = 1728;
  localparam int          TOT2 = 800;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ifm_addr_gen_if #(.ADDR_WIDTH(AW)) b1 ();
  ifm_addr_gen_if #(.ADDR_WIDTH(AW)) b2 ();

  ifm_addr_gen #(
    .KERNEL_SIZE(3), .STRIDE(1), .COL_STEP(16), .IFM_SIZE(34), .IFM_CHANNEL(3),
    .ADDR_WIDTH(AW)
  ) dut1 (.clk(clk), .rst(rst), .bus(b1));

  ifm_addr_gen #(
    .KERNEL_SIZE(5), .STRIDE(2), .COL_STEP(8), .IFM_SIZE(20), .IFM_CHANNEL(2),
    .ADDR_WIDTH(AW)
  ) dut2 (.clk(clk), .rst(rst), .bus(b2));

  int errors = 0;
  int checks = 0;

  int            idx1 = 0, idx2 = 0;
  logic [AW-1:0] base1 = '0, base2 = '0;
  bit            en1 = 0, en2 = 0;
  logic [AW-1:0] log1 [2048];
  logic [AW-1:0] log2 [1024];
  int            exp10 [10] = '{0, 1, 2, 34, 35, 36, 68, 69, 70, 1156};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Address of the i-th handshake, decoded straight from the loop nest.
  function automatic logic [AW-1:0] model(input int i, input logic [AW-1:0] base,
                                          input int k, input int s, input int cs,
                                          input int ifm, input int c);
    int kx, ky, ch, col, row, ncols, off;
    ncols = (ifm - k) / cs + 1;
    kx  = i % k;  i = i / k;
    ky  = i % k;  i = i / k;
    ch  = i % c;  i = i / c;
    col = i % ncols;
    row = i / ncols;
    off = ch * ifm * ifm + (row * s + ky) * ifm + col * cs + kx;
    return base + AW'(off);
  endfunction

  always @(negedge clk) begin
    if (en1) begin
      if (b1.addr_valid) begin
        chk("addr1", 32'(b1.ifm_addr), 32'(model(idx1, base1, 3, 1, 16, 34, 3)));
`ifdef IFM_ADDR_GEN_LAST_EN
        chk("win_last1", 32'(b1.win_last), 32'(((idx1 + 1) % 27) == 0));
`endif
        if (b1.addr_ready) begin
          if (idx1 < 2048) log1[idx1] = b1.ifm_addr;
          idx1++;
        end
      end else begin
`ifdef IFM_ADDR_GEN_LAST_EN
        chk("win_last1_idle", 32'(b1.win_last), 0);
`endif
      end
      if (b1.busy && !b1.done) chk("valid1_in_emit", 32'(b1.addr_valid), 1);
      if (b1.done) chk("done1_hs_count", idx1, TOT1);
    end
    if (en2) begin
      if (b2.addr_valid) begin
        chk("addr2", 32'(b2.ifm_addr), 32'(model(idx2, base2, 5, 2, 8, 20, 2)));
`ifdef IFM_ADDR_GEN_LAST_EN
        chk("win_last2", 32'(b2.win_last), 32'(((idx2 + 1) % 50) == 0));
`endif
        if (b2.addr_ready) begin
          if (idx2 < 1024) log2[idx2] = b2.ifm_addr;
          idx2++;
        end
      end
      if (b2.busy && !b2.done) chk("valid2_in_emit", 32'(b2.addr_valid), 1);
      if (b2.done) chk("done2_hs_count", idx2, TOT2);
    end
  end

  task automatic start1(input logic [AW-1:0] base);
    @(posedge clk); #1;
    base1 = base; idx1 = 0; en1 = 1;
    b1.ifm_base = base; b1.start = 1'b1;
    @(posedge clk); #1;
    b1.start = 1'b0; b1.ifm_base = '0;
    chk("start_valid", 32'(b1.addr_valid), 1);
    chk("start_busy", 32'(b1.busy), 1);
    chk("start_addr", 32'(b1.ifm_addr), 32'(base));
  endtask

  // mode 0: ready always high; mode 1: random ready.
  task automatic finish1(input int mode, input int budget);
    int  n = 0;
    bit  seen = 0;
    while (!seen && n < budget) begin
      @(posedge clk); #1;
      b1.addr_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (b1.done) seen = 1;
      n++;
    end
    if (!seen) begin
      chk("done_timeout", 0, 1);
    end else begin
      chk("done_valid_low", 32'(b1.addr_valid), 0);
      chk("done_busy_high", 32'(b1.busy), 1);
      b1.start = 1'b1;
      b1.ifm_base = 19'd999;
      @(posedge clk); #1;
      b1.start = 1'b0;
      chk("done_one_cycle", 32'(b1.done), 0);
      chk("busy_fall", 32'(b1.busy), 0);
      chk("start_in_done_ignored", 32'(b1.addr_valid), 0);
    end
    b1.addr_ready = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    b1.start = 0; b1.ifm_base = '0; b1.addr_ready = 0;
    b2.start = 0; b2.ifm_base = '0; b2.addr_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", 32'(b1.ifm_addr), 0);
    chk("rst_valid", 32'(b1.addr_valid), 0);
    chk("rst_busy", 32'(b1.busy), 0);
    chk("rst_done", 32'(b1.done), 0);
`ifdef IFM_ADDR_GEN_LAST_EN
    chk("rst_win_last", 32'(b1.win_last), 0);
`endif
    rst = 1'b0;

    // Basic run
    b1.addr_ready = 1'b1;
    start1(19'd0);
    finish1(0, 3000);
    for (int i = 0; i < 10; i++) chk("basic_first10", 32'(log1[i]), exp10[i]);
    chk("basic_27th", 32'(log1[26]), 2382);
    chk("basic_win2", 32'(log1[27]), 16);
    chk("basic_win3", 32'(log1[54]), 34);
    chk("basic_last", 32'(log1[TOT1-1]), 3452);

    // Back-pressure while 35 is presented
    b1.addr_ready = 1'b1;
    start1(19'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("bp_at_35", 32'(b1.ifm_addr), 35);
    b1.addr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_addr", 32'(b1.ifm_addr), 35);
      chk("bp_hold_valid", 32'(b1.addr_valid), 1);
    end
    @(posedge clk); #1;
    b1.addr_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_next", 32'(b1.ifm_addr), 36);
    finish1(0, 3000);

    // Random ready over a full run
    start1(19'd0);
    finish1(1, 10000);
    chk("rand_last", 32'(log1[TOT1-1]), 3452);

    // start during EMIT is ignored
    start1(19'd0);
    repeat (100) @(posedge clk);
    #1;
    b1.start = 1'b1; b1.ifm_base = 19'd777;
    @(posedge clk); #1;
    b1.start = 1'b0; b1.ifm_base = '0;
    chk("emit_start_busy", 32'(b1.busy), 1);
    finish1(0, 3000);

    // Base offset and wrap
    start1(19'd100000);
    finish1(0, 3000);
    chk("base_first", 32'(log1[0]), 100000);
    start1(19'h7FFFF);
    finish1(0, 3000);
    chk("wrap_second", 32'(log1[1]), 0);

    // Reset mid-run after 1200 handshakes
    start1(19'd0);
    n = 0;
    while (idx1 < 1200 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b1; en1 = 0;
    @(posedge clk); #1;
    chk("midrst_valid", 32'(b1.addr_valid), 0);
    chk("midrst_busy", 32'(b1.busy), 0);
    chk("midrst_addr", 32'(b1.ifm_addr), 0);
    chk("midrst_done", 32'(b1.done), 0);
    rst = 1'b0;
    start1(19'd5000);
    finish1(0, 3000);

    // Alternate geometry
    b2.addr_ready = 1'b1;
    @(posedge clk); #1;
    base2 = 19'd300; idx2 = 0; en2 = 1;
    b2.ifm_base = 19'd300; b2.start = 1'b1;
    @(posedge clk); #1;
    b2.start = 1'b0; b2.ifm_base = '0;
    chk("alt_first", 32'(b2.ifm_addr), 300);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!b2.done && n < 2000);
    chk("alt_done_seen", 32'(b2.done), 1);
    chk("alt_second_ky", 32'(log2[5]), 320);
    chk("alt_second_ch", 32'(log2[25]), 700);
    chk("alt_win2", 32'(log2[50]), 308);
    chk("alt_row2", 32'(log2[100]), 340);
    chk("alt_last", 32'(log2[TOT2-1]), 1072);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
